// File: rtl/jtag_uart_pkg.sv
// Shared constants and FSM state type for the JTAG-UART host-bound encoder.
package jtag_uart_pkg;

    localparam logic [7:0] ESC_BYTE = 8'hFE;
    localparam logic [7:0] CMD_IDLE = 8'h00;
    localparam logic [7:0] CMD_ACK  = 8'h01;

    localparam logic JTAG_ADDR_DATA = 1'b0;
    localparam logic JTAG_ADDR_CTRL = 1'b1;

    localparam int WSPACE_HI = 31;
    localparam int WSPACE_LO = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POLL,
        ST_GAP,
        ST_WR
    } tx_state_t;

    // Byte placed on the data register: the owed prefix goes out first.
    function automatic logic [7:0] wire_byte(input logic esc, input logic [7:0] b);
        return esc ? ESC_BYTE : b;
    endfunction

endpackage

// File: rtl/jtag_uart_wspace_credit.sv
// UART write-space credit (load from poll, decrement per write) and poll back-off timer.
module jtag_uart_wspace_credit
    import jtag_uart_pkg::*;
#(
    parameter int POLL_GAP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        dec,
    input  logic        gap_run,
    output logic        credit_zero,
    output logic        credit_last,
    output logic        gap_done
);

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    logic [15:0] credit;
    logic [15:0] gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= 16'd0;
        end else if (load) begin
            credit <= load_value;
        end else if (dec && credit != 16'd0) begin
            credit <= credit - 16'd1;
        end
    end

    // Timer restarts every time the FSM enters the back-off state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= 16'd0;
        end else if (!gap_run) begin
            gap_cnt <= 16'd0;
        end else begin
            gap_cnt <= gap_cnt + 16'd1;
        end
    end

    assign credit_zero = (credit == 16'd0);
    assign credit_last = (credit == 16'd1);
    assign gap_done    = gap_run && (gap_cnt == GAP_LAST);

endmodule

// File: rtl/jtag_uart_encode.sv
// Host-bound JTAG-UART transmitter: 0xFE escaping, WSPACE-gated Avalon-MM writes.
// Optional automatic ACK insertion is enabled by defining JTAG_UART_AUTO_ACK_EN.
module jtag_uart_encode
    import jtag_uart_pkg::*;
#(
    parameter int POLL_GAP = 64
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [7:0]  iTX_DATA,
    input  logic        iTX_CMD,
    input  logic        iTX_VALID,
    output logic        oTX_READY,
    input  logic        iACK_REQ,
    output logic        oJTAG_SLAVE_ADDR,
    output logic        oJTAG_SLAVE_RDREQ,
    input  logic [31:0] iJTAG_SLAVE_RDDATA,
    output logic        oJTAG_SLAVE_WRREQ,
    output logic [31:0] oJTAG_SLAVE_WRDATA,
    input  logic        iJTAG_SLAVE_WAIT,
    output logic        oBUSY,
    output logic [15:0] oTX_COUNT
);

    tx_state_t   state, state_nx;
    logic [7:0]  byte_q;
    logic        esc_q;
    logic [15:0] tx_count;

    logic        ack_take;
    logic        load_en;
    logic [7:0]  load_byte;
    logic        load_esc;
    logic        rd_done;
    logic        wr_done;
    logic        credit_zero;
    logic        credit_last;
    logic        gap_done;

    logic [15:0] wspace;
    logic [15:0] rd_unused;

    assign wspace    = iJTAG_SLAVE_RDDATA[WSPACE_HI:WSPACE_LO];
    assign rd_unused = iJTAG_SLAVE_RDDATA[WSPACE_LO-1:0];

`ifdef JTAG_UART_AUTO_ACK_EN
    logic ack_pending;

    // A request arriving in ST_IDLE is taken the same cycle, so it never needs the flag.
    assign ack_take = ack_pending || iACK_REQ;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ack_pending <= 1'b0;
        end else if (state == ST_IDLE) begin
            ack_pending <= 1'b0;
        end else if (iACK_REQ) begin
            ack_pending <= 1'b1;
        end
    end
`else
    logic ack_unused;

    assign ack_unused = iACK_REQ;
    assign ack_take   = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        load_en   = 1'b0;
        load_byte = iTX_DATA;
        load_esc  = iTX_CMD || (iTX_DATA == ESC_BYTE);
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ack_take) begin
                    load_en   = 1'b1;
                    load_byte = CMD_ACK;
                    load_esc  = 1'b1;
                end else if (iTX_VALID) begin
                    load_en = 1'b1;
                end
                if (load_en) begin
                    state_nx = credit_zero ? ST_POLL : ST_WR;
                end
            end
            ST_POLL: begin
                if (!iJTAG_SLAVE_WAIT) begin
                    rd_done  = 1'b1;
                    state_nx = (wspace == 16'd0) ? ST_GAP : ST_WR;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_nx = ST_POLL;
                end
            end
            ST_WR: begin
                if (!iJTAG_SLAVE_WAIT) begin
                    wr_done = 1'b1;
                    if (esc_q) begin
                        state_nx = credit_last ? ST_POLL : ST_WR;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= ST_IDLE;
            byte_q   <= CMD_IDLE;
            esc_q    <= 1'b0;
            tx_count <= 16'd0;
        end else begin
            state <= state_nx;
            if (load_en) begin
                byte_q <= load_byte;
                esc_q  <= load_esc;
            end else if (wr_done) begin
                esc_q <= 1'b0;
            end
            if (wr_done) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end

    jtag_uart_wspace_credit #(
        .POLL_GAP (POLL_GAP)
    ) u_credit (
        .clk         (iCLK),
        .rst_n       (iRST_N),
        .load        (rd_done),
        .load_value  (wspace),
        .dec         (wr_done),
        .gap_run     (state == ST_GAP),
        .credit_zero (credit_zero),
        .credit_last (credit_last),
        .gap_done    (gap_done)
    );

    // Bus outputs decode straight from registered state, so they hold while WAIT is high.
    assign oTX_READY          = iRST_N && (state == ST_IDLE) && !ack_take;
    assign oJTAG_SLAVE_RDREQ  = (state == ST_POLL);
    assign oJTAG_SLAVE_WRREQ  = (state == ST_WR);
    assign oJTAG_SLAVE_ADDR   = (state == ST_POLL) ? JTAG_ADDR_CTRL : JTAG_ADDR_DATA;
    assign oJTAG_SLAVE_WRDATA = (state == ST_WR) ? {24'd0, wire_byte(esc_q, byte_q)} : 32'd0;
    assign oBUSY              = (state != ST_IDLE);
    assign oTX_COUNT          = tx_count;

endmodule
